// File: rtl/usb_line_ctrl.sv
// Half-duplex line-direction controller for the full-speed USB PHY: arbitrates RX/TX, enforces the inter-packet gap.
// Latency: tx_req sampled at edge n gives oe=1 and tx_grant=1 after edge n; every output is registered.
// Backpressure: tx_req is held until tx_grant; RX and the gap defer TX. Optional macro: USB_RESP_TIMEOUT_EN.
module usb_line_ctrl #(
  parameter int IPG_CLKS          = 10,
  parameter int RESP_TIMEOUT_CLKS = 90,
  parameter int CNT_W             = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_start,
  input  logic       rx_finish,
  input  logic       rx_error,
  input  logic       tx_req,
  input  logic       tx_expect_resp,
  input  logic       tx_done,
  output logic       oe,
  output logic       tx_grant,
  output logic       rx_busy,
  output logic       resp_timeout,
  output logic [2:0] ctrl_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RX   = 3'd1,
    S_GAP  = 3'd2,
    S_TX   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // The counter is loaded with CLKS-1, so each load value must fit in CNT_W bits.
  if (IPG_CLKS < 1 || IPG_CLKS > (1 << CNT_W) ||
      RESP_TIMEOUT_CLKS < 1 || RESP_TIMEOUT_CLKS > (1 << CNT_W)) begin : g_bad_cfg
    $error("usb_line_ctrl: CNT_W too narrow for IPG_CLKS/RESP_TIMEOUT_CLKS");
  end

  localparam logic [CNT_W-1:0] IPG_LOAD = CNT_W'(IPG_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef USB_RESP_TIMEOUT_EN
  localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESP_TIMEOUT_CLKS - 1);
`endif

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             exp_r;
  logic             exp_nxt;
  logic             exp_eff;
  logic             timeout_nxt;

  // Next-state, counter and latched-expectation logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    timeout_nxt = 1'b0;
    exp_nxt     = exp_r;
    // A tx_done on the grant cycle must still see this packet's expect flag.
    exp_eff     = tx_grant ? tx_expect_resp : exp_r;

    case (state)
      S_IDLE: begin
        if (rx_start) begin
          state_nxt = S_RX;
        end else if (tx_req) begin
          state_nxt = S_TX;
        end
      end
      S_RX: begin
        if (rx_finish || rx_error) begin
          state_nxt = S_GAP;
          cnt_nxt   = IPG_LOAD;
        end
      end
      S_GAP: begin
        if (rx_start) begin
          state_nxt = S_RX;
        end else if (cnt == '0) begin
          state_nxt = tx_req ? S_TX : S_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_TX: begin
        // rx_* are ignored here: the receiver sees our own echo.
        if (tx_grant) begin
          exp_nxt = tx_expect_resp;
        end
        if (tx_done) begin
          if (exp_eff) begin
            state_nxt = S_RESP;
`ifdef USB_RESP_TIMEOUT_EN
            cnt_nxt   = RESP_LOAD;
`endif
          end else begin
            state_nxt = S_GAP;
            cnt_nxt   = IPG_LOAD;
          end
        end
      end
      S_RESP: begin
`ifdef USB_RESP_TIMEOUT_EN
        if (rx_start) begin
          state_nxt = S_RX;
        end else if (cnt == '0) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_GAP;
          cnt_nxt     = IPG_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
`else
        // Without the timeout the host waits indefinitely for a response.
        if (rx_start) begin
          state_nxt = S_RX;
        end
`endif
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (state_nxt == S_IDLE) begin
      exp_nxt = 1'b0;
    end
  end

  // State, counter and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      exp_r        <= 1'b0;
      oe           <= 1'b0;
      tx_grant     <= 1'b0;
      rx_busy      <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      exp_r        <= exp_nxt;
      oe           <= (state_nxt == S_TX);
      tx_grant     <= (state_nxt == S_TX) && (state != S_TX);
      rx_busy      <= (state_nxt == S_RX);
      resp_timeout <= timeout_nxt;
    end
  end

  assign ctrl_state = state;

endmodule
